// File: rtl/sprite_engine_pkg.sv
// rtl/sprite_engine_pkg.sv - shared types and constants for the sprite frame engine
//
// Holds the FSM state encoding (also driven out on the state debug port),
// the pixel colour width and the default screen geometry.
package sprite_engine_pkg;

    typedef enum logic [3:0] {
        ST_CLEAR  = 4'd0,
        ST_INIT   = 4'd1,
        ST_IDLE   = 4'd2,
        ST_ERASE  = 4'd3,
        ST_UPDATE = 4'd4,
        ST_DRAW   = 4'd5
    } state_e;

    localparam int COLOUR_W = 3;

    localparam int SCREEN_W_DEFAULT = 160;
    localparam int SCREEN_H_DEFAULT = 120;
    localparam int X_W_DEFAULT      = 8;
    localparam int Y_W_DEFAULT      = 7;

endpackage

// File: rtl/sprite_frame_tick.sv
// rtl/sprite_frame_tick.sv - free-running frame tick divider
//
// Ports:
//   CLOCK_50  in   sole clock, rising edge
//   resetn    in   asynchronous active-low reset
//   tick      out  one-cycle pulse every FRAME_DIV cycles
//
// The down-counter reloads to FRAME_DIV-1 and the tick is high while it
// sits at zero, so the first tick is sampled FRAME_DIV edges after reset
// release.
module sprite_frame_tick #(
    parameter int FRAME_DIV = 833333
) (
    input  logic CLOCK_50,
    input  logic resetn,
    output logic tick
);

    localparam int               CNT_W  = $clog2(FRAME_DIV + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(FRAME_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= RELOAD;
        end else if (cnt_q == '0) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/sprite_engine.sv
// rtl/sprite_engine.sv - frame engine drawing N vertically-moving sprites
//
// Optional feature macro: SPRITE_ENGINE_CLEAR_EN (screen clear pass after reset).
//
// Ports:
//   CLOCK_50  in   sole clock, rising edge
//   resetn    in   asynchronous active-low reset
//   enable    in   frame ticks are ignored in IDLE while low
//   up/down   in   per-sprite move requests, sampled in that sprite's UPDATE cycle
//   x/y       out  pixel coordinate
//   colour    out  pixel colour
//   plot      out  x/y/colour valid this cycle
//   busy      out  high in every state except IDLE
//   overrun   out  sticky: a tick arrived while not IDLE
//   state     out  current FSM state for debug LEDs
module sprite_engine
    import sprite_engine_pkg::*;
#(
    parameter int N_SPRITES = 2,
    parameter int SPR_W     = 8,
    parameter int SPR_H     = 16,
    parameter int SCREEN_W  = SCREEN_W_DEFAULT,
    parameter int SCREEN_H  = SCREEN_H_DEFAULT,
    parameter int X_W       = X_W_DEFAULT,
    parameter int Y_W       = Y_W_DEFAULT,
    parameter int Y_MIN     = 10,
    parameter int Y_MAX     = 100,
    parameter int STEP      = 1,
    parameter int FRAME_DIV = 833333,
    parameter logic [N_SPRITES*X_W-1:0]      INIT_X  = {8'd10, 8'd144},
    parameter logic [N_SPRITES*Y_W-1:0]      INIT_Y  = {7'd50, 7'd50},
    parameter logic [N_SPRITES*COLOUR_W-1:0] COLOURS = {3'b111, 3'b011}
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic [N_SPRITES-1:0] up,
    input  logic [N_SPRITES-1:0] down,
    output logic [X_W-1:0]       x,
    output logic [Y_W-1:0]       y,
    output logic [COLOUR_W-1:0]  colour,
    output logic                 plot,
    output logic                 busy,
    output logic                 overrun,
    output logic [3:0]           state
);

    localparam int IDX_W = $clog2(N_SPRITES) + 1;
    localparam int COL_W = $clog2(SPR_W + 1);
    localparam int ROW_W = $clog2(SPR_H + 1);

    // Position arithmetic is one bit wider than a coordinate so that
    // y - STEP and y + STEP can be compared against the bounds safely.
    localparam logic [Y_W:0] STEP_E     = (Y_W + 1)'(STEP);
    localparam logic [Y_W:0] YMIN_STEP  = (Y_W + 1)'(Y_MIN + STEP);
    localparam logic [Y_W:0] YMAX_E     = (Y_W + 1)'(Y_MAX);

`ifdef SPRITE_ENGINE_CLEAR_EN
    localparam state_e RESET_STATE = ST_CLEAR;
`else
    localparam state_e RESET_STATE = ST_INIT;
    localparam int     UNUSED_SCREEN_AREA = SCREEN_W * SCREEN_H;
`endif

    logic tick;

    sprite_frame_tick #(
        .FRAME_DIV (FRAME_DIV)
    ) u_tick (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .tick     (tick)
    );

    state_e               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [COL_W-1:0]     col_q;
    logic [ROW_W-1:0]     row_q;
    logic [Y_W-1:0]       pos_q [N_SPRITES];
    logic [X_W-1:0]       x_q;
    logic [Y_W-1:0]       y_q;
    logic [COLOUR_W-1:0]  colour_q;
    logic                 plot_q;
    logic                 busy_q;
    logic                 overrun_q;
`ifdef SPRITE_ENGINE_CLEAR_EN
    logic [X_W-1:0]       cx_q;
    logic [Y_W-1:0]       cy_q;
`endif

    // Per-sprite view of the currently indexed sprite.
    logic [X_W-1:0]      cur_x;
    logic [Y_W-1:0]      cur_y;
    logic [COLOUR_W-1:0] cur_colour;
    logic                cur_up;
    logic                cur_down;
    logic [Y_W:0]        y_ext;
    logic [Y_W-1:0]      new_y_d;
    logic                col_last;
    logic                spr_last;
    logic                idx_last;

    always_comb begin
        cur_x      = '0;
        cur_y      = '0;
        cur_colour = '0;
        cur_up     = 1'b0;
        cur_down   = 1'b0;
        for (int i = 0; i < N_SPRITES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_x      = INIT_X[i*X_W +: X_W];
                cur_y      = pos_q[i];
                cur_colour = COLOURS[i*COLOUR_W +: COLOUR_W];
                cur_up     = up[i];
                cur_down   = down[i];
            end
        end
    end

    always_comb begin
        y_ext   = {1'b0, cur_y};
        new_y_d = cur_y;
        if (cur_up && !cur_down) begin
            new_y_d = (y_ext < YMIN_STEP) ? Y_W'(Y_MIN) : Y_W'(y_ext - STEP_E);
        end else if (cur_down && !cur_up) begin
            new_y_d = ((y_ext + STEP_E) > YMAX_E) ? Y_W'(Y_MAX) : Y_W'(y_ext + STEP_E);
        end
    end

    assign col_last = (col_q == COL_W'(SPR_W - 1));
    assign spr_last = col_last && (row_q == ROW_W'(SPR_H - 1));
    assign idx_last = (idx_q == IDX_W'(N_SPRITES - 1));

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= RESET_STATE;
            idx_q     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < N_SPRITES; i++) begin
                pos_q[i] <= INIT_Y[i*Y_W +: Y_W];
            end
`ifdef SPRITE_ENGINE_CLEAR_EN
            cx_q      <= '0;
            cy_q      <= '0;
`endif
        end else begin
            plot_q <= 1'b0;
            busy_q <= 1'b1;
            if (tick && state_q != ST_IDLE) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
`ifdef SPRITE_ENGINE_CLEAR_EN
                ST_CLEAR: begin
                    x_q      <= cx_q;
                    y_q      <= cy_q;
                    colour_q <= '0;
                    plot_q   <= 1'b1;
                    if (cx_q == X_W'(SCREEN_W - 1)) begin
                        cx_q <= '0;
                        if (cy_q == Y_W'(SCREEN_H - 1)) begin
                            cy_q    <= '0;
                            state_q <= ST_INIT;
                        end else begin
                            cy_q <= cy_q + 1'b1;
                        end
                    end else begin
                        cx_q <= cx_q + 1'b1;
                    end
                end
`endif
                ST_INIT, ST_ERASE, ST_DRAW: begin
                    x_q      <= cur_x + X_W'(col_q);
                    y_q      <= cur_y + Y_W'(row_q);
                    colour_q <= (state_q == ST_ERASE) ? '0 : cur_colour;
                    plot_q   <= 1'b1;
                    if (col_last) begin
                        col_q <= '0;
                        row_q <= spr_last ? '0 : row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                    if (spr_last) begin
                        if (state_q == ST_ERASE) begin
                            state_q <= ST_UPDATE;
                        end else if (idx_last) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            idx_q   <= '0;
                        end else begin
                            // INIT walks straight to the next sprite; a frame
                            // erases the next sprite before drawing it.
                            state_q <= (state_q == ST_INIT) ? ST_INIT : ST_ERASE;
                            idx_q   <= idx_q + 1'b1;
                        end
                    end
                end
                ST_UPDATE: begin
                    for (int i = 0; i < N_SPRITES; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            pos_q[i] <= new_y_d;
                        end
                    end
                    state_q <= ST_DRAW;
                end
                ST_IDLE: begin
                    if (tick && enable) begin
                        state_q <= ST_ERASE;
                        idx_q   <= '0;
                        col_q   <= '0;
                        row_q   <= '0;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign colour  = colour_q;
    assign plot    = plot_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;
    assign state   = state_q;

endmodule

// File: tb/tb_sprite_engine.sv
// tb/tb_sprite_engine.sv - randomized self-checking bench for sprite_engine
module tb_sprite_engine;

`ifdef SPRITE_ENGINE_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1_n, rst2_n, en, sel;
    logic [1:0] up, down;
    logic [7:0] x1, x2;
    logic [6:0] y1, y2;
    logic [2:0] c1, c2;
    logic       p1, p2, b1, b2, o1, o2;
    logic [3:0] s1, s2;

    sprite_engine #(.FRAME_DIV(600)) dut1 (
        .CLOCK_50 (clk), .resetn (rst1_n), .enable (en), .up (up), .down (down),
        .x (x1), .y (y1), .colour (c1), .plot (p1), .busy (b1), .overrun (o1), .state (s1)
    );

    sprite_engine #(.FRAME_DIV(300), .STEP(4)) dut2 (
        .CLOCK_50 (clk), .resetn (rst2_n), .enable (en), .up (up), .down (down),
        .x (x2), .y (y2), .colour (c2), .plot (p2), .busy (b2), .overrun (o2), .state (s2)
    );

    logic [7:0] mon_x;
    logic [6:0] mon_y;
    logic [2:0] mon_c;
    logic       mon_p, mon_b, mon_o;
    logic [3:0] mon_s;

    always_comb begin
        if (sel) begin
            mon_x = x2; mon_y = y2; mon_c = c2; mon_p = p2; mon_b = b2; mon_o = o2; mon_s = s2;
        end else begin
            mon_x = x1; mon_y = y1; mon_c = c1; mon_p = p1; mon_b = b1; mon_o = o1; mon_s = s1;
        end
    end

    // Reference model: sprite geometry and positions straight from the rules.
    int ix   [2] = '{144, 10};
    int icol [2] = '{3, 7};
    int py   [2];
    int step;
    int last_wait;
    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [31:0] pk(input int px, input int pyv, input int pc);
        return 32'((px << 10) | (pyv << 3) | pc);
    endfunction

    function automatic int move(input int yv, input bit u, input bit d, input int st);
        if (u && !d) return (yv - st < 10) ? 10 : yv - st;
        if (d && !u) return (yv + st > 100) ? 100 : yv + st;
        return yv;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic finish_up();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    endtask

    task automatic next_pixel();
        last_wait = 0;
        @(negedge clk);
        while (!mon_p && last_wait < 3000) begin
            @(negedge clk);
            last_wait++;
        end
        if (!mon_p) begin
            check("pixel_timeout", 32'(mon_p), 32'd1);
            finish_up();
        end
    endtask

    task automatic expect_rect(input int x0, input int y0, input int col, input string tag);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 8; c++) begin
                next_pixel();
                check(tag, pk(mon_x, mon_y, mon_c), pk(x0 + c, y0 + r, col));
            end
        end
    endtask

    task automatic frame(input logic [1:0] u, input logic [1:0] d, input bit exp_ovr);
        up   = u;
        down = d;
        for (int i = 0; i < 2; i++) begin
            expect_rect(ix[i], py[i], 0, "erase_px");
            py[i] = move(py[i], u[i], d[i], step);
            expect_rect(ix[i], py[i], icol[i], "draw_px");
        end
        check("frame_end_busy", 32'(mon_b), 32'd0);
        check("frame_end_state", 32'(mon_s), 32'd2);
        check("frame_overrun", 32'(mon_o), 32'(exp_ovr));
    endtask

    task automatic do_reset(input bit which);
        int first_w;
        if (which) rst2_n = 1'b0; else rst1_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_plot", 32'(mon_p), 32'd0);
        check("rst_overrun", 32'(mon_o), 32'd0);
        check("rst_busy", 32'(mon_b), 32'd0);
        check("rst_xyc", pk(mon_x, mon_y, mon_c), 32'd0);
        check("rst_state", 32'(mon_s), CLR ? 32'd0 : 32'd1);
        py[0] = 50;
        py[1] = 50;
        if (which) rst2_n = 1'b1; else rst1_n = 1'b1;
        first_w = -1;
`ifdef SPRITE_ENGINE_CLEAR_EN
        for (int yy = 0; yy < 120; yy++) begin
            for (int xx = 0; xx < 160; xx++) begin
                next_pixel();
                if (first_w < 0) first_w = last_wait;
                check("clear_px", pk(mon_x, mon_y, mon_c), pk(xx, yy, 0));
            end
        end
`endif
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 16; r++) begin
                for (int c = 0; c < 8; c++) begin
                    next_pixel();
                    if (first_w < 0) first_w = last_wait;
                    check("init_px", pk(mon_x, mon_y, mon_c), pk(ix[i] + c, py[i] + r, icol[i]));
                end
            end
        end
        check("first_px_latency", 32'(first_w), 32'd0);
        check("init_busy", 32'(mon_b), 32'd0);
        check("init_state", 32'(mon_s), 32'd2);
        check("init_overrun", 32'(mon_o), 32'(CLR));
    endtask

    initial begin
        int plots;
        logic [1:0] u, d;
        rst1_n = 1'b1;
        rst2_n = 1'b0;
        en     = 1'b1;
        up     = '0;
        down   = '0;
        sel    = 1'b0;
        step   = 1;
        @(negedge clk);

        // dut1: start-up, enable gating, random frames, both-pressed, reset mid-draw.
        do_reset(1'b0);
        en = 1'b0;
        plots = 0;
        repeat (700) begin
            @(negedge clk);
            if (mon_p) plots++;
        end
        check("enable_low_no_plot", 32'(plots), 32'd0);
        check("enable_low_overrun", 32'(mon_o), 32'(CLR));
        en = 1'b1;

        frame({1'b1, 1'($urandom_range(0, 1))}, {1'b1, 1'($urandom_range(0, 1))}, CLR);
        for (int k = 0; k < 5; k++) begin
            u = 2'($urandom_range(0, 3));
            d = 2'($urandom_range(0, 3));
            frame(u, d, CLR);
        end
        for (int k = 0; k < 11; k++) begin
            frame({1'($urandom_range(0, 1)), 1'b1}, {1'($urandom_range(0, 1)), 1'b0}, CLR);
        end

        up   = 2'b01;
        down = 2'b00;
        expect_rect(ix[0], py[0], 0, "erase_px");
        py[0] = move(py[0], 1'b1, 1'b0, step);
        for (int c = 0; c < 8; c++) begin
            next_pixel();
            check("partial_draw_px", pk(mon_x, mon_y, mon_c), pk(ix[0] + c, py[0], icol[0]));
        end
        check("mid_draw_state", 32'(mon_s), 32'd5);
        do_reset(1'b0);

        // dut2: STEP=4 clamps at both bounds; frames overrun FRAME_DIV=300.
        rst1_n = 1'b0;
        sel    = 1'b1;
        step   = 4;
        do_reset(1'b1);
        for (int k = 0; k < 11; k++) begin
            frame({1'($urandom_range(0, 1)), 1'b1}, {1'($urandom_range(0, 1)), 1'b0}, 1'b1);
        end
        for (int k = 0; k < 23; k++) begin
            frame({1'($urandom_range(0, 1)), 1'b0}, {1'($urandom_range(0, 1)), 1'b1}, 1'b1);
        end
        finish_up();
    end

    initial begin
        #2000000;
        check("watchdog", 32'd0, 32'd1);
        finish_up();
    end

endmodule
